// File: rtl/ad_bus_pkg.sv
// ad_bus_pkg: shared AD-bus constants and FSM state encoding
package ad_bus_pkg;
    localparam int AD_W    = 8;
    localparam int AD_N_CH = 4;
    localparam int AD_AW   = 4;
    localparam int AD_TMO  = 15;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/ad_bus_tmo.sv
// ad_bus_tmo: counts ADDR cycles without ds; expired fires on the TMO-th idle cycle
module ad_bus_tmo import ad_bus_pkg::*; #(
    parameter int TMO = AD_TMO
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);
    logic [7:0] cnt;
    assign expired = en && (cnt == 8'(TMO - 1));
    // restart on every address latch, otherwise count waiting cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 8'd1;
    end
endmodule

// File: rtl/ad_bus_switch.sv
// ad_bus_switch: multiplexed address/data bus to N_CH channel registers
module ad_bus_switch import ad_bus_pkg::*; #(
    parameter int W    = AD_W,
    parameter int N_CH = AD_N_CH,
    parameter int AW   = AD_AW,
    parameter int TMO  = AD_TMO
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W-1:0]      ad_in,
    input  logic              ale,
    input  logic              ds,
    input  logic              wr,
    input  logic              err_clr,
    input  logic [N_CH*W-1:0] ch_in,
    output logic [W-1:0]      ad_out,
    output logic              ad_oe,
    output logic              rdy,
    output logic [N_CH*W-1:0] ch_dat,
    output logic [N_CH-1:0]   ch_upd,
    output logic              err
);
    state_t          state, state_d;
    logic [AW-1:0]   adr_q;
    logic            wr_q;
    logic            go, valid, relatch, tmo_en, expired;
    logic [W-1:0]    rd_word;
    logic [N_CH-1:0] upd_d;

    assign go      = state == ADDR && ds;
    assign valid   = 32'(adr_q) < N_CH;
    assign relatch = ale && (state == IDLE || (state == ADDR && !ds));
    assign tmo_en  = state == ADDR && !ds && !ale;
    assign rdy     = state == DONE;

    ad_bus_tmo #(.TMO(TMO)) u_tmo (
        .clk(clk),
        .rst(rst),
        .load(relatch),
        .en(tmo_en),
        .expired(expired)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    // next state: ds ends ADDR, timeout falls back to IDLE, DONE waits for ds release
    always_comb begin
        state_d = (state == IDLE) ? (ale ? ADDR : IDLE) :
                  (state == ADDR) ? (ds ? DONE : (expired ? IDLE : ADDR)) :
                  (ds ? DONE : IDLE);
    end

    // decode latched address into read mux and write strobes; out-of-range decodes to nothing
    always_comb begin
        rd_word = '0;
        upd_d   = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (32'(adr_q) == i) begin
                rd_word  = ch_in[i*W +: W];
                upd_d[i] = go && wr_q;
            end
        end
    end

    // channel write registers hold until the next write to them
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ch_dat <= '0;
        else
            for (int i = 0; i < N_CH; i++)
                if (upd_d[i])
                    ch_dat[i*W +: W] <= ad_in;
    end

    // address latch, read data, update pulses and sticky error (set beats clear)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adr_q  <= '0;
            wr_q   <= 1'b0;
            ad_out <= '0;
            ad_oe  <= 1'b0;
            ch_upd <= '0;
            err    <= 1'b0;
        end else begin
            if (relatch) begin
                adr_q <= ad_in[AW-1:0];
                wr_q  <= wr;
            end
            if (go && !wr_q) begin
                ad_out <= rd_word;
                ad_oe  <= 1'b1;
            end else if (state == DONE && !ds) begin
                ad_out <= '0;
                ad_oe  <= 1'b0;
            end
            ch_upd <= upd_d;
            err    <= ((go && !valid) || expired) ? 1'b1 : (err_clr ? 1'b0 : err);
        end
    end
endmodule

// File: tb/tb_ad_bus_switch.sv
// tb_ad_bus_switch: table-driven transfers with a scoreboard plus timing corner sequences
module tb_ad_bus_switch;
    typedef struct {
        logic [7:0] adr;
        logic       w;
        logic [7:0] data;
        logic [7:0] e_out;
        logic       e_oe;
        logic [3:0] e_upd;
        logic       e_err;
    } vec_t;
    typedef struct {
        logic [7:0]  out;
        logic        oe;
        logic [3:0]  upd;
        logic        err;
        logic [31:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  ad_in = '0;
    logic        ale = 1'b0, ds = 1'b0, wr = 1'b0, err_clr = 1'b0;
    logic [31:0] ch_in = {8'h4D, 8'h92, 8'h3C, 8'h17};
    logic [7:0]  ad_out;
    logic        ad_oe, rdy, err;
    logic [31:0] ch_dat;
    logic [3:0]  ch_upd;

    int          errors = 0;
    int          checks = 0;
    exp_t        sbq[$];
    logic [31:0] m_dat = '0;
    logic        rdy_p = 1'b0;
    vec_t        vt[10];

    ad_bus_switch dut (
        .clk(clk), .rst(rst), .ad_in(ad_in), .ale(ale), .ds(ds), .wr(wr),
        .err_clr(err_clr), .ch_in(ch_in), .ad_out(ad_out), .ad_oe(ad_oe),
        .rdy(rdy), .ch_dat(ch_dat), .ch_upd(ch_upd), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ale_ph(input logic [7:0] a, input logic w_i);
        ad_in = a;
        wr    = w_i;
        ale   = 1'b1;
        tick();
        ale   = 1'b0;
    endtask

    task automatic ds_ph(input logic [7:0] d, input exp_t e);
        ad_in = d;
        ds    = 1'b1;
        sbq.push_back(e);
        tick();
        chk("rdy_latency", rdy, 1);
        tick();
        chk("rdy_hold", rdy, 1);
        chk("upd_one_cycle", ch_upd, 0);
        chk("oe_hold", ad_oe, e.oe);
        ds = 1'b0;
        tick();
        chk("rdy_drop", rdy, 0);
        chk("oe_drop", ad_oe, 0);
        chk("out_drop", ad_out, 0);
    endtask

    // scoreboard: compare on the cycle rdy first rises
    always @(negedge clk) begin
        if (rdy && !rdy_p) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_rdy", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_ad_out", ad_out, e.out);
                chk("sb_ad_oe", ad_oe, e.oe);
                chk("sb_ch_upd", ch_upd, e.upd);
                chk("sb_err", err, e.err);
                chk("sb_ch_dat", ch_dat, e.dat);
            end
        end
        rdy_p = rdy;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{8'h02, 1'b1, 8'hA5, 8'h00, 1'b0, 4'b0100, 1'b0};
        vt[1] = '{8'h00, 1'b1, 8'h11, 8'h00, 1'b0, 4'b0001, 1'b0};
        vt[2] = '{8'h03, 1'b1, 8'hC7, 8'h00, 1'b0, 4'b1000, 1'b0};
        vt[3] = '{8'h01, 1'b0, 8'h00, 8'h3C, 1'b1, 4'b0000, 1'b0};
        vt[4] = '{8'h03, 1'b0, 8'h00, 8'h4D, 1'b1, 4'b0000, 1'b0};
        vt[5] = '{8'h07, 1'b1, 8'hFF, 8'h00, 1'b0, 4'b0000, 1'b1};
        vt[6] = '{8'h0F, 1'b0, 8'h00, 8'h00, 1'b1, 4'b0000, 1'b1};
        vt[7] = '{8'h01, 1'b1, 8'h5A, 8'h00, 1'b0, 4'b0010, 1'b0};
        vt[8] = '{8'h00, 1'b0, 8'h00, 8'h17, 1'b1, 4'b0000, 1'b0};
        vt[9] = '{8'h12, 1'b0, 8'h00, 8'h92, 1'b1, 4'b0000, 1'b0};

        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ad_out", ad_out, 0);
        chk("rst_ad_oe", ad_oe, 0);
        chk("rst_rdy", rdy, 0);
        chk("rst_ch_dat", ch_dat, 0);
        chk("rst_ch_upd", ch_upd, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        tick();

        for (int k = 0; k < 10; k++) begin
            exp_t e;
            if (vt[k].w && vt[k].adr[3:0] < 4)
                m_dat[vt[k].adr[3:0]*8 +: 8] = vt[k].data;
            e = '{vt[k].e_out, vt[k].e_oe, vt[k].e_upd, vt[k].e_err, m_dat};
            ale_ph(vt[k].adr, vt[k].w);
            ds_ph(vt[k].data, e);
            chk("vec_ch_dat_hold", ch_dat, m_dat);
            if (vt[k].e_err) begin
                tick();
                chk("err_sticky", err, 1);
                err_clr = 1'b1;
                tick();
                err_clr = 1'b0;
                chk("err_cleared", err, 0);
            end
        end

        begin
            exp_t e;
            ale_ph(8'h00, 1'b1);
            ad_in = 8'h66;
            wr    = 1'b0;
            ale   = 1'b1;
            m_dat[7:0] = 8'h66;
            e = '{8'h00, 1'b0, 4'b0001, 1'b0, m_dat};
            ds_ph(8'h66, e);
            ale = 1'b0;
            chk("collision_dat", ch_dat, m_dat);
        end

        begin
            exp_t e;
            ale_ph(8'h00, 1'b1);
            repeat (10) tick();
            ale_ph(8'h03, 1'b1);
            repeat (14) tick();
            chk("relatch_no_tmo", err, 0);
            m_dat[31:24] = 8'h11;
            e = '{8'h00, 1'b0, 4'b1000, 1'b0, m_dat};
            ds_ph(8'h11, e);
            chk("relatch_dat", ch_dat, m_dat);
        end

        ale_ph(8'h01, 1'b0);
        repeat (14) tick();
        chk("tmo_not_early", err, 0);
        tick();
        chk("tmo_err", err, 1);
        chk("tmo_rdy", rdy, 0);
        ad_in = 8'h99;
        ds    = 1'b1;
        tick();
        tick();
        chk("idle_ds_no_rdy", rdy, 0);
        chk("idle_ds_no_oe", ad_oe, 0);
        ds = 1'b0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("tmo_err_clear", err, 0);

        begin
            exp_t e;
            ale_ph(8'h01, 1'b1);
            m_dat[15:8] = 8'h55;
            e = '{8'h00, 1'b0, 4'b0010, 1'b0, m_dat};
            ad_in = 8'h55;
            ds    = 1'b1;
            sbq.push_back(e);
            tick();
            chk("mid_rdy", rdy, 1);
            @(negedge clk);
            #1 rst = 1'b1;
            #1;
            m_dat = '0;
            chk("async_rst_rdy", rdy, 0);
            chk("async_rst_dat", ch_dat, m_dat);
            chk("async_rst_upd", ch_upd, 0);
            #1 rst = 1'b0;
            for (int c = 0; c < 2; c++) begin
                tick();
                chk("post_rst_upd", ch_upd, 0);
                chk("post_rst_rdy", rdy, 0);
            end
            ds = 1'b0;
            tick();
        end

        chk("sb_drain", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
